// File: rtl/instruction_fetch.sv
// Fetch stage for a synchronous (one-cycle latency) instruction memory.
// Owns the PC, drives the memory address, and tags each returned word with its PC and a valid flag.
module instruction_fetch #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned INSTR_W = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   output logic [CNT_W-1:0]   instr_count
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_valid;
   logic [CNT_W-1:0]  r_count;
   logic              w_hold;
   logic              w_consume;

   // A stall with a valid word re-reads the held address so imem_data stays put.
   assign w_hold    = stall && r_valid;
   assign w_consume = r_valid && (!stall || branch_taken);

   always_comb begin
      imem_addr = r_pc;
      if (branch_taken)
         imem_addr = branch_target;
      else if (w_hold)
         imem_addr = r_instr_pc;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc       <= RESET_PC;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
      end else if (branch_taken) begin
         r_instr_pc <= branch_target;
         r_valid    <= 1'b1;
         r_pc       <= branch_target + ADDR_W'(1);
      end else if (!stall) begin
         r_instr_pc <= r_pc;
         r_valid    <= 1'b1;
         r_pc       <= r_pc + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_count <= '0;
      else if (w_consume && (r_count != '1))
         r_count <= r_count + CNT_W'(1);
   end

   assign instr       = imem_data;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign instr_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed plus randomized bench for instruction_fetch against a sequence-level reference model.
module tb_instruction_fetch;

   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          stall;
   logic          branch_taken;
   logic [7:0]    branch_target;
   logic [7:0]    imem_addr;
   logic [7:0]    imem_data;
   logic [7:0]    instr;
   logic [7:0]    instr_pc;
   logic          instr_valid;
   logic [CW-1:0] instr_count;

   logic [7:0] mem [256];
   logic [7:0] prog [8];

   int checks = 0;
   int errors = 0;

   // reference model: next fetch address, pc of delivered word, valid, consumed count
   int m_next;
   int m_ipc;
   bit m_valid;
   int m_count;

   instruction_fetch #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00), .CNT_W(CW)) dut (
      .clock(clock), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
      .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) imem_data <= mem[imem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_next = 0; m_ipc = 0; m_valid = 0; m_count = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"}, instr_valid, m_valid);
      chk({tag, "_pc"}, instr_pc, m_ipc);
      chk({tag, "_count"}, instr_count, m_count);
      if (m_valid) chk({tag, "_instr"}, instr, mem[m_ipc]);
   endtask

   // One clock: drive inputs, check the address, take the edge, then check the delivered word.
   task automatic cyc(input logic s, input logic b, input logic [7:0] t, input string tag);
      int exp_addr;
      stall = s; branch_taken = b; branch_target = t;
      #1;
      if (b) exp_addr = t;
      else if (s && m_valid) exp_addr = m_ipc;
      else exp_addr = m_next;
      chk({tag, "_addr"}, imem_addr, exp_addr);
      @(posedge clock);
      if (m_valid && (!s || b)) m_count = (m_count == CMAX) ? CMAX : m_count + 1;
      if (b) begin
         m_ipc = t; m_valid = 1; m_next = (t + 1) % 256;
      end else if (!s) begin
         m_ipc = m_next; m_valid = 1; m_next = (m_next + 1) % 256;
      end
      #1;
      check_outputs(tag);
   endtask

   // Reset pulse placed between clock edges; outputs must clear without a clock.
   task automatic mid_reset(input string tag);
      #2;
      stall = 0; branch_taken = 0; branch_target = 8'h00;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk({tag, "_rvalid"}, instr_valid, 1'b0);
      chk({tag, "_rcount"}, instr_count, 0);
      chk({tag, "_raddr"}, imem_addr, 8'h00);
      chk({tag, "_rpc"}, instr_pc, 8'h00);
      reset_n = 1'b1;
   endtask

   initial begin
      prog[0] = 8'h11; prog[1] = 8'h2D; prog[2] = 8'h72; prog[3] = 8'h52;
      prog[4] = 8'h90; prog[5] = 8'hA1; prog[6] = 8'hC3; prog[7] = 8'hE0;
      for (int i = 0; i < 256; i++) mem[i] = (i < 8) ? prog[i] : 8'($urandom);

      reset_n = 1'b0; stall = 0; branch_taken = 0; branch_target = 8'h00;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_outputs("reset");
      chk("reset_addr", imem_addr, 8'h00);
      reset_n = 1'b1;

      // test 1: free run over the preloaded program
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 8'h00, "t1");
         chk("t1_const_instr", instr, prog[i]);
      end
      chk("t1_count7", instr_count, 7);

      // test 2: stall while holding pc 2
      mid_reset("t2");
      for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, "t2run");
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 8'h00, "t2stall");
         chk("t2_held_instr", instr, 8'h72);
         chk("t2_held_count", instr_count, 2);
      end
      #1 chk("t2_addr_hold", imem_addr, 8'h02);
      cyc(0, 0, 8'h00, "t2rel");
      chk("t2_next_instr", instr, 8'h52);

      // test 3: branch to 5 from pc 3
      cyc(0, 1, 8'h05, "t3br");
      chk("t3_instr_a1", instr, 8'hA1);
      chk("t3_count", instr_count, 4);
      cyc(0, 0, 8'h00, "t3seq");
      chk("t3_instr_c3", instr, 8'hC3);

      // test 4: branch beats stall
      cyc(1, 1, 8'h01, "t4");
      chk("t4_instr_2d", instr, 8'h2D);

      // test 5: pc wrap through 8'hFF
      cyc(0, 1, 8'hFF, "t5br");
      chk("t5_pc_ff", instr_pc, 8'hFF);
      cyc(0, 0, 8'h00, "t5wrap");
      chk("t5_instr_11", instr, 8'h11);

      // test 6: asynchronous reset mid-run then restart
      mid_reset("t6");
      for (int i = 0; i < 8; i++) cyc(0, 0, 8'h00, "t6run");
      chk("t6_count7", instr_count, 7);

      // stall while nothing valid yet
      mid_reset("t7");
      cyc(1, 0, 8'h00, "t7stall");
      cyc(0, 0, 8'h00, "t7go");

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) mid_reset("rnd");
         else cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                  8'($urandom), "rnd");
      end

      // counter saturation
      mid_reset("sat");
      for (int i = 0; i < CMAX + 6; i++) cyc(0, 0, 8'h00, "sat");
      chk("sat_count", instr_count, CMAX);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
